// File: rtl/xalu.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Results land in HI/LO on the edge that ends the busy window.
module xalu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  XALUOp,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [1:0]    op;      // {is_div, is_unsigned}
    logic [31:0]   op_a, op_b;

    logic [63:0] prod_s, prod_u;
    logic [31:0] dvd, dvs, quo, rem, res_hi, res_lo;
    logic        signed_op, div_zero;

    assign prod_s = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
    assign prod_u = {32'd0, op_a} * {32'd0, op_b};

    // Signed division runs on magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
    always_comb begin
        signed_op = ~op[0];
        dvd = (signed_op && op_a[31]) ? (~op_a + 32'd1) : op_a;
        dvs = (signed_op && op_b[31]) ? (~op_b + 32'd1) : op_b;
        quo = 32'd0;
        rem = 32'd0;
        if (dvs != 32'd0) begin
            quo = dvd / dvs;
            rem = dvd % dvs;
        end
        if (!op[1]) begin
            res_hi = op[0] ? prod_u[63:32] : prod_s[63:32];
            res_lo = op[0] ? prod_u[31:0]  : prod_s[31:0];
        end else begin
            res_lo = (signed_op && (op_a[31] ^ op_b[31])) ? (~quo + 32'd1) : quo;
            res_hi = (signed_op && op_a[31]) ? (~rem + 32'd1) : rem;
        end
        div_zero = op[1] && (op_b == 32'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            op    <= '0;
            op_a  <= '0;
            op_b  <= '0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (XALUOp[2]) begin
                        op    <= XALUOp[1:0];
                        op_a  <= A;
                        op_b  <= B;
                        cnt   <= XALUOp[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        state <= RUN;
                    end else if (XALUOp == 3'b001) begin
                        HI <= A;
                    end else if (XALUOp == 3'b010) begin
                        LO <= A;
                    end
                end
                default: begin
                    if (cnt == CW'(1)) begin
                        if (!div_zero) begin
                            HI <= res_hi;
                            LO <= res_lo;
                        end
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
            endcase
        end
    end

    assign busy = (state == RUN);
endmodule

// File: tb/tb_xalu.sv
// Directed bench for xalu: vector table for single ops plus sequences for
// mid-run interference, reset abort and back-to-back start at completion.
module tb_xalu;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, B;
    logic [2:0]  XALUOp;
    logic        busy;
    logic [31:0] HI, LO;

    int total = 0;
    int bad   = 0;

    xalu dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .XALUOp(XALUOp),
        .busy(busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
        int          cyc;
    } vec_t;

    vec_t vecs[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Counts busy cycles from the current sample, verifying HI/LO never move mid-run.
    task automatic wait_idle(input logic [31:0] h0, input logic [31:0] l0,
                             output int n, output bit held);
        n = 0;
        held = 1'b1;
        while (busy && n < 100) begin
            if (HI !== h0 || LO !== l0) held = 1'b0;
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        bit held;
        logic [31:0] h0, l0;

        vecs[0]  = '{3'b100, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        vecs[1]  = '{3'b101, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2]  = '{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{3'b111, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 10};
        vecs[4]  = '{3'b001, 32'h12345678, 32'h0,        32'h12345678, 32'h00000003, 0};
        vecs[5]  = '{3'b010, 32'h9ABCDEF0, 32'h0,        32'h12345678, 32'h9ABCDEF0, 0};
        vecs[6]  = '{3'b110, 32'h00000005, 32'h0,        32'h12345678, 32'h9ABCDEF0, 10};
        vecs[7]  = '{3'b111, 32'h00000005, 32'h0,        32'h12345678, 32'h9ABCDEF0, 10};
        vecs[8]  = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[9]  = '{3'b000, 32'h00000001, 32'h1,        32'h00000000, 32'h80000000, 0};
        vecs[10] = '{3'b011, 32'h00000001, 32'h1,        32'h00000000, 32'h80000000, 0};
        vecs[11] = '{3'b100, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 5};
        vecs[12] = '{3'b110, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[13] = '{3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};

        // Reset wins over a start op presented on the same edge.
        reset = 1'b1; A = 32'hDEADBEEF; B = 32'h3; XALUOp = 3'b100;
        tick();
        tick();
        XALUOp = 3'b000;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);
        reset = 1'b0;
        tick();
        chk("post_reset_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 14; i++) begin
            h0 = HI; l0 = LO;
            A = vecs[i].a; B = vecs[i].b; XALUOp = vecs[i].op;
            tick();
            XALUOp = 3'b000;
            wait_idle(h0, l0, n, held);
            chk($sformatf("v%0d_cycles", i), n, vecs[i].cyc);
            chk($sformatf("v%0d_hold", i), {31'd0, held}, 32'd1);
            chk($sformatf("v%0d_hi", i), HI, vecs[i].hi);
            chk($sformatf("v%0d_lo", i), LO, vecs[i].lo);
        end

        // Operand changes and mthi during busy cycles 2-4 must not leak in.
        h0 = HI; l0 = LO;
        A = 32'd3; B = 32'd5; XALUOp = 3'b100;
        tick();
        XALUOp = 3'b000;
        n = 0; held = 1'b1;
        while (busy && n < 100) begin
            if (HI !== h0 || LO !== l0) held = 1'b0;
            n++;
            if (n >= 2 && n <= 4) begin
                A = 32'd100; B = 32'd100; XALUOp = 3'b001;
            end else begin
                XALUOp = 3'b000;
            end
            tick();
        end
        XALUOp = 3'b000;
        chk("mid_cycles", n, 32'd5);
        chk("mid_hold", {31'd0, held}, 32'd1);
        chk("mid_hi", HI, 32'd0);
        chk("mid_lo", LO, 32'd15);
        tick();
        chk("mid_hi_after", HI, 32'd0);

        // Reset in busy cycle 4 of a div discards the pending result.
        A = 32'hAAAA5555; XALUOp = 3'b001;
        tick();
        A = 32'd100; B = 32'd7; XALUOp = 3'b110;
        tick();
        XALUOp = 3'b000;
        n = 1;
        while (n < 4) begin
            n++;
            tick();
        end
        chk("abort_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", HI, 32'd0);
        chk("abort_lo", LO, 32'd0);
        held = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) held = 1'b0;
        end
        chk("abort_no_write", {31'd0, held}, 32'd1);

        // Start presented on the completion edge is dropped; same op next cycle is taken.
        A = 32'h80000000; B = 32'hFFFFFFFF; XALUOp = 3'b110;
        tick();
        XALUOp = 3'b000;
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (n == 10) begin
                A = 32'd9; B = 32'd2; XALUOp = 3'b111;
            end
            tick();
        end
        chk("b2b_cycles", n, 32'd10);
        chk("b2b_busy_gap", {31'd0, busy}, 32'd0);
        chk("b2b_hi", HI, 32'd0);
        chk("b2b_lo", LO, 32'h80000000);
        h0 = HI; l0 = LO;
        tick();
        XALUOp = 3'b000;
        chk("b2b_accept", {31'd0, busy}, 32'd1);
        wait_idle(h0, l0, n, held);
        chk("b2b2_cycles", n, 32'd10);
        chk("b2b2_hold", {31'd0, held}, 32'd1);
        chk("b2b2_hi", HI, 32'd1);
        chk("b2b2_lo", LO, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
